// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture block: FSM states, CRC constants
// and the bit layout of the 8-bit VGA PMOD bus.
package vga_capture_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // vga_pmod = {hs, b1, g1, r1, vs, b0, g0, r0}
  localparam int unsigned PMOD_R0 = 0;
  localparam int unsigned PMOD_G0 = 1;
  localparam int unsigned PMOD_B0 = 2;
  localparam int unsigned PMOD_VS = 3;
  localparam int unsigned PMOD_R1 = 4;
  localparam int unsigned PMOD_G1 = 5;
  localparam int unsigned PMOD_B1 = 6;
  localparam int unsigned PMOD_HS = 7;

  function automatic logic [5:0] pmod_pixel(input logic [7:0] p);
    return {p[PMOD_B1], p[PMOD_B0], p[PMOD_G1], p[PMOD_G0], p[PMOD_R1], p[PMOD_R0]};
  endfunction

endpackage

// File: rtl/crc16_sym6.sv
// Combinational CRC-16-CCITT update by one 6-bit symbol, MSB first.
module crc16_sym6
  import vga_capture_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [5:0]  sym,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in;
    for (int unsigned i = 0; i < 6; i++) begin
      if (acc[15] ^ sym[3'(5 - i)]) acc = {acc[14:0], 1'b0} ^ CRC_POLY;
      else                         acc = {acc[14:0], 1'b0};
    end
    crc_out = acc;
  end

endmodule

// File: rtl/vga_capture.sv
// Passive VGA timing analyser: measures sync timing, locks onto a stable mode,
// CRCs each frame's active pixels and samples one probe pixel per frame.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned VGA_WIDTH    = 640,
  parameter int unsigned VGA_HEIGHT   = 480,
  parameter int unsigned H_BACK_PORCH = 48,
  parameter int unsigned V_BACK_PORCH = 33,
  parameter logic        SYNC_ACTIVE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_pmod,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [5:0]  probe_rgb,
  output logic        probe_valid,
  output logic        frame_done,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] hsync_width,
  output logic [9:0]  v_total,
  output logic [9:0]  vsync_width,
  output logic [15:0] frame_crc
);

  localparam logic [10:0] H_START   = 11'(H_BACK_PORCH);
  localparam logic [10:0] H_END     = 11'(H_BACK_PORCH + VGA_WIDTH);
  localparam logic [9:0]  V_START   = 10'(V_BACK_PORCH);
  localparam logic [9:0]  V_END     = 10'(V_BACK_PORCH + VGA_HEIGHT);
  localparam logic [10:0] H_MAX     = '1;
  localparam logic [9:0]  V_MAX     = '1;
  localparam logic [7:0]  PMOD_IDLE = {~SYNC_ACTIVE, 3'b000, ~SYNC_ACTIVE, 3'b000};

  state_t      state, state_nxt;
  logic [7:0]  pmod_q;
  logic        hs_prev, vs_prev;
  logic        hs_act, vs_act, h_edge, v_edge;
  logic [10:0] hcount, hcount_cur, hs_cnt, x_cur;
  logic [9:0]  vcount, vcount_cur, vl_cnt, vs_lines, vt_new, y_cur;
  logic [9:0]  px_q, py_q;
  logic        v_pend, line_bad;
  logic        h_mismatch, vt_match, pix_active, probe_hit;
  logic [5:0]  pixel;
  logic [15:0] crc_run, crc_next;

  assign hs_act = (pmod_q[PMOD_HS] == SYNC_ACTIVE);
  assign vs_act = (pmod_q[PMOD_VS] == SYNC_ACTIVE);
  assign h_edge = (hs_prev == SYNC_ACTIVE) && !hs_act;
  assign v_edge = (vs_prev == SYNC_ACTIVE) && !vs_act;
  assign pixel  = pmod_pixel(pmod_q);
  assign locked = (state == ST_LOCKED);

  // Counters are resolved for the current sample so hcount reads 0 on the edge cycle.
  always_comb begin
    hcount_cur = h_edge ? '0 : ((hcount == H_MAX) ? H_MAX : hcount + 11'd1);
    vcount_cur = vcount;
    if (h_edge) vcount_cur = v_pend ? '0 : ((vcount == V_MAX) ? V_MAX : vcount + 10'd1);
    x_cur      = hcount_cur - H_START;
    y_cur      = vcount_cur - V_START;
    pix_active = (state != ST_SEARCH) &&
                 (hcount_cur >= H_START) && (hcount_cur < H_END) &&
                 (vcount_cur >= V_START) && (vcount_cur < V_END);
    probe_hit  = pix_active && (x_cur == {1'b0, px_q}) && (y_cur == py_q);
    h_mismatch = (hcount + 11'd1) != h_total;
    vt_new     = (h_edge && vl_cnt != V_MAX) ? vl_cnt + 10'd1 : vl_cnt;
    vt_match   = (vt_new == v_total);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: if (v_edge) state_nxt = ST_TRACK;
      ST_TRACK:  if (v_edge && vt_match && !line_bad && !(h_edge && h_mismatch))
                   state_nxt = ST_LOCKED;
      ST_LOCKED: if ((h_edge && h_mismatch) || (v_edge && !vt_match))
                   state_nxt = ST_TRACK;
      default:   state_nxt = ST_SEARCH;
    endcase
  end

  crc16_sym6 u_crc (
    .crc_in  (crc_run),
    .sym     (pixel),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmod_q  <= PMOD_IDLE;
      hs_prev <= ~SYNC_ACTIVE;
      vs_prev <= ~SYNC_ACTIVE;
      state   <= ST_SEARCH;
      hcount  <= '0;
      vcount  <= '0;
    end else begin
      pmod_q  <= vga_pmod;
      hs_prev <= pmod_q[PMOD_HS];
      vs_prev <= pmod_q[PMOD_VS];
      state   <= state_nxt;
      hcount  <= hcount_cur;
      vcount  <= vcount_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_total     <= '0;
      hsync_width <= '0;
      hs_cnt      <= '0;
    end else if (h_edge) begin
      h_total     <= hcount + 11'd1;
      hsync_width <= hs_cnt;
      hs_cnt      <= '0;
    end else if (hs_act && hs_cnt != H_MAX) begin
      hs_cnt <= hs_cnt + 11'd1;
    end
  end

  // A coincident hsync edge is folded into the closing frame; the vcount
  // restart is deferred to the next hsync edge via v_pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_total     <= '0;
      vsync_width <= '0;
      vl_cnt      <= '0;
      vs_lines    <= '0;
      v_pend      <= 1'b0;
      line_bad    <= 1'b0;
    end else begin
      if (h_edge) begin
        v_pend <= 1'b0;
        vl_cnt <= vt_new;
        if (vs_act && vs_lines != V_MAX) vs_lines <= vs_lines + 10'd1;
        if (h_mismatch) line_bad <= 1'b1;
      end
      if (v_edge) begin
        v_total     <= vt_new;
        vsync_width <= vs_lines;
        vl_cnt      <= '0;
        vs_lines    <= '0;
        v_pend      <= 1'b1;
        line_bad    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_run     <= CRC_INIT;
      frame_crc   <= '0;
      frame_done  <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      frame_done <= v_edge && (state != ST_SEARCH);
      if (v_edge && state != ST_SEARCH) begin
        frame_crc <= crc_run;
        crc_run   <= CRC_INIT;
      end else if (pix_active) begin
        crc_run <= crc_next;
      end
      if (v_edge) begin
        px_q        <= probe_x;
        py_q        <= probe_y;
        probe_valid <= 1'b0;
      end else if (probe_hit) begin
        probe_rgb   <= pixel;
        probe_valid <= 1'b1;
      end
    end
  end

endmodule
